// File: rtl/bram_nrport_1wport_bypass.sv
// Multi-read-port, single byte-enabled write-port block RAM.
// Every read port is registered. Read-during-write to the same index returns
// either the old entry or the merged new bytes. An optional post-reset sweep
// zeroes every entry before the array is reported usable.
module bram_nrport_1wport_bypass #(
  parameter int unsigned INNER_WIDTH    = 32,
  parameter int unsigned OUTER_WIDTH    = 32,
  parameter int unsigned NUM_RPORTS     = 2,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter              INIT_FILE      = "",
  localparam int unsigned IW = (OUTER_WIDTH > 1) ? $clog2(OUTER_WIDTH) : 1,
  localparam int unsigned NB = INNER_WIDTH / 8
) (
  input  logic                                   CLK,
  input  logic                                   nRST,
  input  logic [NUM_RPORTS-1:0]                  port_ren,
  input  logic [NUM_RPORTS-1:0][IW-1:0]          port_rindex,
  output logic [NUM_RPORTS-1:0][INNER_WIDTH-1:0] port_rdata,
  input  logic [NB-1:0]                          wen_byte,
  input  logic [IW-1:0]                          windex,
  input  logic [INNER_WIDTH-1:0]                 wdata,
  output logic                                   init_done
);

  typedef enum logic {INIT, READY} state_t;

  state_t                 state, state_next;
  logic [IW-1:0]          ptr, ptr_next;
  logic                   sweep_last;
  logic                   wr_en;
  logic [INNER_WIDTH-1:0] mem [OUTER_WIDTH];
  logic [INNER_WIDTH-1:0] rd_next [NUM_RPORTS];

  // Replace the bytes selected by be in old_word with those of new_word.
  function automatic logic [INNER_WIDTH-1:0] merge_bytes(
    input logic [INNER_WIDTH-1:0] old_word,
    input logic [INNER_WIDTH-1:0] new_word,
    input logic [NB-1:0]          be
  );
    merge_bytes = old_word;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) merge_bytes[8*k +: 8] = new_word[8*k +: 8];
    end
  endfunction

  assign sweep_last = (32'(ptr) == OUTER_WIDTH - 1);
  assign init_done  = (state == READY);
  // User writes count only once usable, outside reset, and inside the depth.
  assign wr_en      = nRST && (state == READY) && (|wen_byte) &&
                      (32'(windex) < OUTER_WIDTH);

  // State and sweep pointer register; reset restarts the sweep from entry 0.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= (CLEAR_ON_RESET != 0) ? INIT : READY;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Sweep sequencing: one entry per cycle, leave INIT after the last entry.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (state == INIT) begin
      if (sweep_last) begin
        state_next = READY;
      end else begin
        ptr_next = ptr + 1'b1;
      end
    end
  end

  // Array write: zero fill during the sweep, byte-enabled user writes after.
  always_ff @(posedge CLK) begin
    if (nRST && state == INIT) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wen_byte[k]) mem[windex][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Per-port read value: zero while sweeping or out of range, optional bypass.
  always_comb begin
    for (int p = 0; p < NUM_RPORTS; p++) begin
      rd_next[p] = '0;
      if (state == READY && 32'(port_rindex[p]) < OUTER_WIDTH) begin
        rd_next[p] = mem[port_rindex[p]];
        if (RDW_MODE == 1 && wr_en && port_rindex[p] == windex) begin
          rd_next[p] = merge_bytes(rd_next[p], wdata, wen_byte);
        end
      end
    end
  end

  // Read data registers: cleared by reset, updated only when enabled.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      port_rdata <= '0;
    end else begin
      for (int p = 0; p < NUM_RPORTS; p++) begin
        if (port_ren[p]) port_rdata[p] <= rd_next[p];
      end
    end
  end

endmodule

// File: tb/tb_bram_nrport_1wport_bypass.sv
// Bench for bram_nrport_1wport_bypass: two instances share stimulus, one at
// depth 32 with old-data read-during-write, one at depth 20 with write-first.
module tb_bram_nrport_1wport_bypass;
  localparam int NP = 4;

  logic                 clk    = 1'b0;
  logic                 nrst   = 1'b0;
  logic [NP-1:0]        ren    = '0;
  logic [NP-1:0][4:0]   rindex = '0;
  logic [3:0]           wen    = '0;
  logic [4:0]           windex = '0;
  logic [31:0]          wdata  = '0;
  logic [NP-1:0][31:0]  rdata_a, rdata_b;
  logic                 done_a, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bram_nrport_1wport_bypass #(
    .INNER_WIDTH(32), .OUTER_WIDTH(32), .NUM_RPORTS(NP),
    .RDW_MODE(0), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) dut_a (
    .CLK(clk), .nRST(nrst), .port_ren(ren), .port_rindex(rindex),
    .port_rdata(rdata_a), .wen_byte(wen), .windex(windex), .wdata(wdata),
    .init_done(done_a)
  );

  bram_nrport_1wport_bypass #(
    .INNER_WIDTH(32), .OUTER_WIDTH(20), .NUM_RPORTS(NP),
    .RDW_MODE(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) dut_b (
    .CLK(clk), .nRST(nrst), .port_ren(ren), .port_rindex(rindex),
    .port_rdata(rdata_b), .wen_byte(wen), .windex(windex), .wdata(wdata),
    .init_done(done_b)
  );

  // Reference model: index 0 models dut_a, index 1 models dut_b.
  logic [31:0] ref_mem [2][32];
  logic [31:0] exp_rd  [2][NP];
  int          sweep_cnt [2];
  bit          in_sweep  [2];
  int          mdl_depth;
  logic [31:0] mdl_mask;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    byte_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  always @(posedge clk) begin
    mdl_mask = byte_mask(wen);
    for (int d = 0; d < 2; d++) begin
      mdl_depth = (d == 0) ? 32 : 20;
      if (!nrst) begin
        for (int p = 0; p < NP; p++) exp_rd[d][p] = 32'h0;
        sweep_cnt[d] = 0;
        in_sweep[d]  = 1'b1;
      end else if (in_sweep[d]) begin
        for (int p = 0; p < NP; p++) if (ren[p]) exp_rd[d][p] = 32'h0;
        ref_mem[d][sweep_cnt[d]] = 32'h0;
        sweep_cnt[d] = sweep_cnt[d] + 1;
        if (sweep_cnt[d] == mdl_depth) in_sweep[d] = 1'b0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (ren[p]) begin
            if (int'(rindex[p]) >= mdl_depth) begin
              exp_rd[d][p] = 32'h0;
            end else begin
              exp_rd[d][p] = ref_mem[d][rindex[p]];
              if (d == 1 && wen != 4'h0 && rindex[p] == windex)
                exp_rd[d][p] = (exp_rd[d][p] & ~mdl_mask) | (wdata & mdl_mask);
            end
          end
        end
        if (wen != 4'h0 && int'(windex) < mdl_depth)
          ref_mem[d][windex] = (ref_mem[d][windex] & ~mdl_mask) | (wdata & mdl_mask);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int rise_a, rise_b;
    nrst = 1'b0; ren = '0; wen = '0;
    tick(); tick();
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (rdata_a[p] !== 32'h0 || rdata_b[p] !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_rdata port%0d: got %h/%h expected 0", p, rdata_a[p], rdata_b[p]);
      end
    end
    n_cmp++;
    if (done_a !== 1'b0 || done_b !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_init_done: got %b/%b expected 0/0", done_a, done_b);
    end
    nrst = 1'b1;
    rise_a = -1; rise_b = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 3) begin
        wen = 4'hF; windex = 5'd3; wdata = 32'hDEADBEEF;
      end else begin
        wen = 4'h0;
      end
      tick();
      if (done_a === 1'b1 && rise_a < 0) rise_a = c;
      if (done_b === 1'b1 && rise_b < 0) rise_b = c;
      if (rise_a > 0 && rise_b > 0) break;
    end
    wen = 4'h0;
    n_cmp++;
    if (rise_a != 32) begin
      n_bad++;
      $display("FAIL sweep_len_a: init_done rose after %0d cycles, expected 32", rise_a);
    end
    n_cmp++;
    if (rise_b != 20) begin
      n_bad++;
      $display("FAIL sweep_len_b: init_done rose after %0d cycles, expected 20", rise_b);
    end
    ren = 4'b0001; rindex[0] = 5'd3;
    tick();
    ren = '0;
    n_cmp++;
    if (rdata_a[0] !== 32'h0 || rdata_b[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL init_write_dropped: got %h/%h expected 0", rdata_a[0], rdata_b[0]);
    end
  endtask

  task automatic test_byte_write();
    wen = 4'hF; windex = 5'd5; wdata = 32'h11223344;
    tick();
    wen = 4'b0101; wdata = 32'hAABBCCDD;
    tick();
    wen = 4'h0; ren = 4'hF;
    for (int p = 0; p < NP; p++) rindex[p] = 5'd5;
    tick();
    ren = '0;
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (rdata_a[p] !== 32'h11BB33DD || rdata_b[p] !== 32'h11BB33DD) begin
        n_bad++;
        $display("FAIL byte_write port%0d: got %h/%h expected 11bb33dd", p, rdata_a[p], rdata_b[p]);
      end
    end
  endtask

  task automatic test_rdw();
    wen = 4'b0011; windex = 5'd7; wdata = 32'hCAFEF00D;
    ren = 4'b0001; rindex[0] = 5'd7;
    tick();
    wen = 4'h0;
    n_cmp++;
    if (rdata_a[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL rdw_old_data: got %h expected 00000000", rdata_a[0]);
    end
    n_cmp++;
    if (rdata_b[0] !== 32'h0000F00D) begin
      n_bad++;
      $display("FAIL rdw_write_first: got %h expected 0000f00d", rdata_b[0]);
    end
    tick();
    ren = '0;
    n_cmp++;
    if (rdata_a[0] !== 32'h0000F00D || rdata_b[0] !== 32'h0000F00D) begin
      n_bad++;
      $display("FAIL rdw_after: got %h/%h expected 0000f00d", rdata_a[0], rdata_b[0]);
    end
  endtask

  task automatic test_hold();
    wen = 4'hF; windex = 5'd2; wdata = 32'h12345678;
    tick();
    wen = 4'h0; ren = 4'b0010; rindex[1] = 5'd2;
    tick();
    ren = '0;
    n_cmp++;
    if (rdata_a[1] !== 32'h12345678 || rdata_b[1] !== 32'h12345678) begin
      n_bad++;
      $display("FAIL hold_initial: got %h/%h expected 12345678", rdata_a[1], rdata_b[1]);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        wen = 4'hF; windex = 5'd2; wdata = 32'h0;
      end else begin
        wen = 4'h0;
      end
      tick();
      n_cmp++;
      if (rdata_a[1] !== 32'h12345678 || rdata_b[1] !== 32'h12345678) begin
        n_bad++;
        $display("FAIL hold_cycle%0d: got %h/%h expected 12345678", c, rdata_a[1], rdata_b[1]);
      end
    end
    ren = 4'b0010;
    tick();
    ren = '0;
    n_cmp++;
    if (rdata_a[1] !== 32'h0 || rdata_b[1] !== 32'h0) begin
      n_bad++;
      $display("FAIL hold_release: got %h/%h expected 0", rdata_a[1], rdata_b[1]);
    end
  endtask

  task automatic test_out_of_range();
    wen = 4'hF; windex = 5'd19; wdata = 32'h5A5A5A5A;
    tick();
    windex = 5'd25; wdata = 32'hFFFFFFFF;
    tick();
    wen = 4'h0; ren = 4'b0011; rindex[0] = 5'd25; rindex[1] = 5'd19;
    tick();
    ren = '0;
    n_cmp++;
    if (rdata_b[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL oor_read_b: got %h expected 0", rdata_b[0]);
    end
    n_cmp++;
    if (rdata_a[0] !== 32'hFFFFFFFF) begin
      n_bad++;
      $display("FAIL in_range_25_a: got %h expected ffffffff", rdata_a[0]);
    end
    n_cmp++;
    if (rdata_a[1] !== 32'h5A5A5A5A || rdata_b[1] !== 32'h5A5A5A5A) begin
      n_bad++;
      $display("FAIL idx19_kept: got %h/%h expected 5a5a5a5a", rdata_a[1], rdata_b[1]);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int rise_a, rise_b;
    ren = 4'hF;
    for (int p = 0; p < NP; p++) rindex[p] = 5'd19;
    tick();
    nrst = 1'b0; ren = '0;
    tick();
    nrst = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    nrst = 1'b0;
    tick();
    for (int p = 0; p < NP; p++) begin
      n_cmp++;
      if (rdata_a[p] !== 32'h0 || rdata_b[p] !== 32'h0) begin
        n_bad++;
        $display("FAIL midreset_rdata port%0d: got %h/%h expected 0", p, rdata_a[p], rdata_b[p]);
      end
    end
    nrst = 1'b1;
    rise_a = -1; rise_b = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done_a === 1'b1 && rise_a < 0) rise_a = c;
      if (done_b === 1'b1 && rise_b < 0) rise_b = c;
      if (rise_a > 0 && rise_b > 0) break;
    end
    n_cmp++;
    if (rise_a != 32 || rise_b != 20) begin
      n_bad++;
      $display("FAIL midreset_sweep_len: got %0d/%0d expected 32/20", rise_a, rise_b);
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int cyc = 0; cyc < 400; cyc++) begin
      windex = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      wen    = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      ren    = 4'($urandom_range(0, 15));
      for (int p = 0; p < NP; p++)
        rindex[p] = ($urandom_range(0, 2) == 0) ? windex : 5'($urandom_range(0, 31));
      tick();
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < NP; p++) begin
          got = (d == 0) ? rdata_a[p] : rdata_b[p];
          n_cmp++;
          if (got !== exp_rd[d][p]) begin
            n_bad++;
            $display("FAIL random dut%0d port%0d cyc%0d: got %h expected %h", d, p, cyc, got, exp_rd[d][p]);
          end
        end
      end
      n_cmp++;
      if (done_a !== !in_sweep[0] || done_b !== !in_sweep[1]) begin
        n_bad++;
        $display("FAIL random_init_done cyc%0d: got %b/%b expected 1/1", cyc, done_a, done_b);
      end
    end
    wen = 4'h0; ren = '0;
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_rdw();
    test_hold();
    test_out_of_range();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
